// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath widths and the MEM-stage
// access state encoding.
package mips_pkg;

  localparam int WORD_W    = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory: synchronous write, combinational read, so a
// read and a write to the same word in one cycle returns the old contents.
module data_memory
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] write_data,
  output logic [WORD_W-1:0] read_data
);

  // Contents survive reset; zero only at power-up.
  logic [WORD_W-1:0] mem [2**ADDR_W] = '{default: '0};

  // Store port
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[addr] <= write_data;
    end
  end

  assign read_data = mem[addr];

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: word loads/stores with a modelled access latency, stall
// handshake to upstream, and the MEM/WB pipeline register.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_mem_read,
  input  logic                 in_mem_write,
  input  logic                 in_mem_to_reg,
  input  logic                 in_reg_write,
  input  logic [REG_IDX_W-1:0] in_write_back_destination,
  input  logic [WORD_W-1:0]    in_alu_result,
  input  logic [WORD_W-1:0]    in_write_data,
  output logic                 stall_out,
  output logic                 out_valid,
  output logic                 out_mem_to_reg,
  output logic                 out_reg_write,
  output logic [REG_IDX_W-1:0] out_write_back_destination,
  output logic [WORD_W-1:0]    out_address,
  output logic [WORD_W-1:0]    out_read_data,
  output logic                 misaligned_out
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0);
  localparam bit HAS_WAIT = (MEM_LATENCY > 0);

  mem_state_t       state_r, state_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic             mem_op_s, misaligned_s, aligned_op_s;
  logic             stall_s, access_s, write_en_s;
  logic [WORD_W-1:0] mem_rdata_s;

  assign mem_op_s     = in_valid & (in_mem_read | in_mem_write);
  assign misaligned_s = mem_op_s & (in_alu_result[1:0] != 2'b00);
  assign aligned_op_s = mem_op_s & ~misaligned_s;
  assign write_en_s   = access_s & aligned_op_s & in_mem_write;

  // Stall must vanish the instant reset is asserted, even with a held op.
  assign stall_out = stall_s & rst_n;

  data_memory #(.ADDR_W(ADDR_W)) u_data_memory (
    .clk        (clk),
    .write_en   (write_en_s),
    .addr       (in_alu_result[ADDR_W+1:2]),
    .write_data (in_write_data),
    .read_data  (mem_rdata_s)
  );

  // Access sequencing: decide stall, completion and the next counter value
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    stall_s      = 1'b0;
    access_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (aligned_op_s && HAS_WAIT) begin
          stall_s      = 1'b1;
          cnt_next_s   = CNT_LOAD;
          state_next_s = WAIT;
        end else if (aligned_op_s) begin
          access_s = 1'b1;
        end else begin
          access_s = 1'b0;
        end
      end
      WAIT: begin
        if (cnt_r == '0) begin
          access_s     = 1'b1;
          state_next_s = IDLE;
        end else begin
          stall_s    = 1'b1;
          cnt_next_s = cnt_r - 1'b1;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = '0;
      end
    endcase
  end

  // FSM state and MEM/WB pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r                    <= IDLE;
      cnt_r                      <= '0;
      out_valid                  <= 1'b0;
      out_mem_to_reg             <= 1'b0;
      out_reg_write              <= 1'b0;
      out_write_back_destination <= '0;
      out_address                <= '0;
      out_read_data              <= '0;
      misaligned_out             <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      if (stall_s) begin
        out_valid                  <= 1'b0;
        out_mem_to_reg             <= 1'b0;
        out_reg_write              <= 1'b0;
        out_write_back_destination <= '0;
        out_address                <= '0;
        out_read_data              <= '0;
        misaligned_out             <= 1'b0;
      end else begin
        out_valid                  <= in_valid;
        out_mem_to_reg             <= in_mem_to_reg;
        out_reg_write              <= in_valid & in_reg_write & ~misaligned_s;
        out_write_back_destination <= in_write_back_destination;
        out_address                <= in_alu_result;
        out_read_data              <= (access_s & in_mem_read) ? mem_rdata_s : '0;
        misaligned_out             <= misaligned_s;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed vector table, reset
// sequences, then random traffic against a word-array reference model.
module tb_mem_access_stage;

  localparam int ADDR_W  = 8;
  localparam int LAT     = 2;
  localparam int MAX_WT  = 20;

  typedef struct packed {
    logic        valid;
    logic        rd;
    logic        wr;
    logic        m2r;
    logic        rw;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] wdata;
  } op_t;

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic        m2r;
    logic [4:0]  dest;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        mis;
  } res_t;

  typedef struct packed {
    op_t         op;
    logic [7:0]  e_stall;
    logic        e_valid;
    logic        e_rw;
    logic [31:0] e_rdata;
    logic        e_mis;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_mem_read = 1'b0, in_mem_write = 1'b0;
  logic        in_mem_to_reg = 1'b0, in_reg_write = 1'b0;
  logic [4:0]  in_write_back_destination = '0;
  logic [31:0] in_alu_result = '0, in_write_data = '0;
  logic        stall_out, out_valid, out_mem_to_reg, out_reg_write, misaligned_out;
  logic [4:0]  out_write_back_destination;
  logic [31:0] out_address, out_read_data;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] model_mem [2**ADDR_W];

  mem_access_stage #(.ADDR_W(ADDR_W), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
    .in_write_back_destination(in_write_back_destination),
    .in_alu_result(in_alu_result), .in_write_data(in_write_data),
    .stall_out(stall_out), .out_valid(out_valid), .out_mem_to_reg(out_mem_to_reg),
    .out_reg_write(out_reg_write), .out_write_back_destination(out_write_back_destination),
    .out_address(out_address), .out_read_data(out_read_data),
    .misaligned_out(misaligned_out)
  );

  always #5 clk = ~clk;

  function automatic res_t sample();
    res_t r;
    r = '{valid: out_valid, rw: out_reg_write, m2r: out_mem_to_reg,
          dest: out_write_back_destination, addr: out_address,
          rdata: out_read_data, mis: misaligned_out};
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Reference: one transaction = one word access on an array, with a fixed
  // stall length for any aligned memory operation.
  task automatic model_step(input op_t o, output res_t e, output int e_stall);
    bit mem_op, mis;
    int idx;
    mem_op  = o.valid && (o.rd || o.wr);
    mis     = mem_op && (o.alu % 4 != 0);
    idx     = (o.alu / 4) % (2**ADDR_W);
    e_stall = (mem_op && !mis) ? LAT : 0;
    e.valid = o.valid;
    e.rw    = o.valid && o.rw && !mis;
    e.m2r   = o.m2r;
    e.dest  = o.dest;
    e.addr  = o.alu;
    e.mis   = mis;
    e.rdata = (mem_op && !mis && o.rd) ? model_mem[idx] : 32'd0;
    if (mem_op && !mis && o.wr) model_mem[idx] = o.wdata;
  endtask

  task automatic drive(input op_t o);
    in_valid = o.valid; in_mem_read = o.rd; in_mem_write = o.wr;
    in_mem_to_reg = o.m2r; in_reg_write = o.rw;
    in_write_back_destination = o.dest;
    in_alu_result = o.alu; in_write_data = o.wdata;
  endtask

  // Present one op, hold it while stalled, return stall count and MEM/WB result
  task automatic apply(input op_t o, output int stalls, output res_t got);
    @(negedge clk);
    drive(o);
    #1;
    stalls = 0;
    while (stall_out && stalls < MAX_WT) begin
      stalls++;
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    if (stall_out) check("stall_timeout", 128'(stall_out), 128'd0);
    @(posedge clk);
    #1;
    got = sample();
  endtask

  vec_t tbl [11];
  op_t  o;
  res_t got, exp;
  int   stalls, e_stall;

  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) model_mem[i] = 32'd0;

    //           valid rd    wr    m2r   rw    dest   alu            wdata           stall  valid rw    rdata          mis
    tbl[0]  = '{'{1'b1,1'b0,1'b0,1'b0,1'b1,5'd5, 32'h0000_1234,32'h0},           8'd0,1'b1,1'b1,32'h0,          1'b0};
    tbl[1]  = '{'{1'b1,1'b0,1'b1,1'b0,1'b0,5'd0, 32'h0000_0010,32'hDEAD_BEEF},   8'd2,1'b1,1'b0,32'h0,          1'b0};
    tbl[2]  = '{'{1'b1,1'b1,1'b0,1'b1,1'b1,5'd8, 32'h0000_0010,32'h0},           8'd2,1'b1,1'b1,32'hDEAD_BEEF,  1'b0};
    tbl[3]  = '{'{1'b1,1'b0,1'b1,1'b0,1'b0,5'd0, 32'h0000_0400,32'hA5A5_A5A5},   8'd2,1'b1,1'b0,32'h0,          1'b0};
    tbl[4]  = '{'{1'b1,1'b1,1'b0,1'b1,1'b1,5'd3, 32'h0000_0000,32'h0},           8'd2,1'b1,1'b1,32'hA5A5_A5A5,  1'b0};
    tbl[5]  = '{'{1'b1,1'b1,1'b0,1'b1,1'b1,5'd9, 32'h0000_0013,32'h0},           8'd0,1'b1,1'b0,32'h0,          1'b1};
    tbl[6]  = '{'{1'b0,1'b1,1'b0,1'b0,1'b1,5'd4, 32'h0000_0013,32'h0},           8'd0,1'b0,1'b0,32'h0,          1'b0};
    tbl[7]  = '{'{1'b1,1'b0,1'b1,1'b0,1'b0,5'd0, 32'h0000_0012,32'h1234_5678},   8'd0,1'b1,1'b0,32'h0,          1'b1};
    tbl[8]  = '{'{1'b1,1'b1,1'b0,1'b1,1'b1,5'd6, 32'h0000_0010,32'h0},           8'd2,1'b1,1'b1,32'hDEAD_BEEF,  1'b0};
    tbl[9]  = '{'{1'b1,1'b1,1'b1,1'b1,1'b1,5'd2, 32'h0000_0010,32'hCAFE_F00D},   8'd2,1'b1,1'b1,32'hDEAD_BEEF,  1'b0};
    tbl[10] = '{'{1'b1,1'b1,1'b0,1'b1,1'b1,5'd7, 32'h0000_0010,32'h0},           8'd2,1'b1,1'b1,32'hCAFE_F00D,  1'b0};

    // Power-up reset, then idle cycles with no valid input
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", 128'(sample()), 128'd0);
    check("reset_stall", 128'(stall_out), 128'd0);

    for (int i = 0; i < 11; i++) begin
      model_step(tbl[i].op, exp, e_stall);
      apply(tbl[i].op, stalls, got);
      exp = '{valid: tbl[i].e_valid, rw: tbl[i].e_rw, m2r: tbl[i].op.m2r,
              dest: tbl[i].op.dest, addr: tbl[i].op.alu,
              rdata: tbl[i].e_rdata, mis: tbl[i].e_mis};
      check($sformatf("vec%0d_stalls", i), 128'(stalls), 128'(tbl[i].e_stall));
      check($sformatf("vec%0d_result", i), 128'(got), 128'(exp));
    end

    // Reset from a populated MEM/WB register clears every output asynchronously
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midstream_reset_outputs", 128'(sample()), 128'd0);
    check("midstream_reset_stall", 128'(stall_out), 128'd0);
    @(negedge clk); drive('0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_valid", 128'(out_valid), 128'd0);

    // Reset while a store sits in WAIT: stall drops at once, write abandoned
    o = '{valid: 1'b1, rd: 1'b0, wr: 1'b1, m2r: 1'b0, rw: 1'b0, dest: 5'd0,
          alu: 32'h20, wdata: 32'h1111_1111};
    @(negedge clk); drive(o);
    @(posedge clk);
    @(negedge clk); #1;
    check("wait_stall_before_reset", 128'(stall_out), 128'd1);
    rst_n = 1'b0;
    #1;
    check("wait_reset_stall", 128'(stall_out), 128'd0);
    @(posedge clk);
    @(negedge clk); drive('0); rst_n = 1'b1;
    o = '{valid: 1'b1, rd: 1'b1, wr: 1'b0, m2r: 1'b1, rw: 1'b1, dest: 5'd1,
          alu: 32'h20, wdata: 32'h0};
    model_step(o, exp, e_stall);
    apply(o, stalls, got);
    check("abandoned_store_rdata", 128'(got.rdata), 128'd0);
    check("abandoned_store_result", 128'(got), 128'(exp));

    // Random traffic against the reference model
    for (int i = 0; i < 200; i++) begin
      o.valid = ($urandom_range(0, 7) != 0);
      o.rd    = $urandom_range(0, 1);
      o.wr    = $urandom_range(0, 2) == 0;
      o.m2r   = $urandom_range(0, 1);
      o.rw    = $urandom_range(0, 1);
      o.dest  = 5'($urandom);
      o.alu   = $urandom & 32'h0000_0FFF;
      if ($urandom_range(0, 7) != 0) o.alu[1:0] = 2'b00;
      o.wdata = $urandom;
      model_step(o, exp, e_stall);
      apply(o, stalls, got);
      check($sformatf("rand%0d_stalls", i), 128'(stalls), 128'(e_stall));
      check($sformatf("rand%0d_result", i), 128'(got), 128'(exp));
    end

    @(negedge clk); drive('0);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
